// File: rtl/series_pkg.sv
// Shared types, widths and the truncating Q0.16 multiply for the power-series evaluator.
package series_pkg;

  localparam int unsigned Q_FRAC        = 16;
  localparam int unsigned ADDR_W        = 4;
  localparam int unsigned RES_W_DEFAULT = 21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  // Full 32-bit product, floor-truncated to the upper 16 bits.
  function automatic logic [Q_FRAC-1:0] mul_q16(input logic [Q_FRAC-1:0] a,
                                                input logic [Q_FRAC-1:0] b);
    return Q_FRAC'(((2*Q_FRAC)'(a) * (2*Q_FRAC)'(b)) >> Q_FRAC);
  endfunction

endpackage

// File: rtl/series_evaluator_q16_mul.sv
// Combinational unsigned Q0.16 x Q0.16 multiply returning product[31:16].
module q16_mul
  import series_pkg::*;
(
  input  logic [Q_FRAC-1:0] a,
  input  logic [Q_FRAC-1:0] b,
  output logic [Q_FRAC-1:0] p
);

  always_comb begin
    p = mul_q16(a, b);
  end

endmodule

// File: rtl/series_evaluator.sv
// Sequential evaluator of P(x) = sum_{k=1..n} s_k * c_k * x^k, one term per clock,
// reading coefficient c_k from an external combinational ROM at address k.
module series_evaluator
  import series_pkg::*;
#(
  parameter int unsigned ALT_SIGN = 0,
  parameter int unsigned RES_W    = RES_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [Q_FRAC-1:0]       x,
  input  logic [ADDR_W-1:0]       n_terms,
  output logic [ADDR_W-1:0]       coef_addr,
  input  logic [Q_FRAC-1:0]       coef_i,
  output logic                    busy,
  output logic                    done,
  output logic [RES_W-1:0]        result
);

  state_e                   state_q, state_d;
  logic [Q_FRAC-1:0]        power_q, power_d;
  logic [Q_FRAC-1:0]        x_q, x_d;
  logic signed [RES_W-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0]        k_q, k_d;
  logic [ADDR_W-1:0]        n_q, n_d;
  logic [RES_W-1:0]         result_q, result_d;

  logic [Q_FRAC-1:0]        term;
  logic [Q_FRAC-1:0]        power_next;
  logic signed [RES_W-1:0]  term_ext;
  logic signed [RES_W-1:0]  acc_next;
  logic                     sub_term;

  q16_mul u_term_mul (
    .a (power_q),
    .b (coef_i),
    .p (term)
  );

  q16_mul u_power_mul (
    .a (power_q),
    .b (x_q),
    .p (power_next)
  );

  // Even-indexed terms are subtracted only in alternating-sign mode.
  always_comb begin
    sub_term = (ALT_SIGN != 0) && !k_q[0];
    term_ext = {{(RES_W-Q_FRAC){1'b0}}, term};
    acc_next = sub_term ? (acc_q - term_ext) : (acc_q + term_ext);
  end

  always_comb begin
    state_d  = state_q;
    power_d  = power_q;
    x_d      = x_q;
    acc_d    = acc_q;
    k_d      = k_q;
    n_d      = n_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          power_d = x;
          x_d     = x;
          acc_d   = '0;
          k_d     = ADDR_W'(1);
          n_d     = n_terms;
          state_d = (n_terms != '0) ? ITER : DONE;
        end
      end
      ITER: begin
        acc_d   = acc_next;
        power_d = power_next;
        k_d     = k_q + ADDR_W'(1);
        if (k_q == n_q) begin
          result_d = acc_next;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      power_q  <= '0;
      x_q      <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      n_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      power_q  <= power_d;
      x_q      <= x_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      n_q      <= n_d;
      result_q <= result_d;
    end
  end

  // Outputs decode registered state only; start and x never reach them combinationally.
  always_comb begin
    coef_addr = (state_q == ITER) ? k_q : '0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    result    = result_q;
  end

endmodule
